lcd_reader: RTL and testbench

Read-side engine for the HD44780-style 8-bit character LCD bus. It performs RW=1 read cycles for two read types:
- busy-flag/address-counter reads (RS=0);
- display-RAM data reads (RS=1).
It returns the captured byte to the fabric. It sits beside the LCD write driver on the slow (10 kHz) clock. The top level tristates the data pins while RW=1.

---
 rtl/lcd_reader.sv | 140 ++++++++++++++
 tb/tb_lcd_reader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_reader.sv
// lcd_reader: RW=1 read engine for an HD44780-style 8-bit LCD bus (busy-flag/address and data reads).
// Define LCD_READ_TIMEOUT_EN to bound busy-flag polling to POLL_LIMIT reads per transaction.
module lcd_reader #(
  parameter int unsigned SETUP_CYCLES   = 1,
  parameter int unsigned EN_HIGH_CYCLES = 2,
  parameter int unsigned POLL_LIMIT     = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       regSel,
  input  logic       pollBusy,
  input  logic [7:0] lcdDataIn,
  output logic       RS,
  output logic       RW,
  output logic       enableOut,
  output logic       busy,
  output logic [7:0] dataOut,
  output logic       busyFlag,
  output logic [6:0] addr,
  output logic       valid,
  output logic       timeout
);

  if (SETUP_CYCLES < 1 || SETUP_CYCLES > 15 || EN_HIGH_CYCLES < 1 || EN_HIGH_CYCLES > 15 ||
      POLL_LIMIT < 1 || POLL_LIMIT > 255) begin : g_bad_param
    $error("lcd_reader: parameter out of range");
  end

  localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] EN_LAST    = 4'(EN_HIGH_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SETUP, EN_HIGH, HOLD, DONE} state_t;

  state_t     state;
  state_t     stateNext;
  logic [3:0] cnt;
  logic       regSelQ;
  logic       pollQ;
  logic [7:0] capture;

`ifdef LCD_READ_TIMEOUT_EN
  localparam logic [7:0] POLL_LAST = 8'(POLL_LIMIT - 1);
  logic [7:0] pollCnt;
  logic       timedOut;
  logic       limitHit;
`endif

  always_comb begin
    stateNext = state;
`ifdef LCD_READ_TIMEOUT_EN
    limitHit  = 1'b0;
`endif
    case (state)
      IDLE:    if (start) stateNext = SETUP;
      SETUP:   if (cnt == SETUP_LAST) stateNext = EN_HIGH;
      EN_HIGH: if (cnt == EN_LAST) stateNext = HOLD;
      HOLD: begin
        if (pollQ && capture[7]) begin
`ifdef LCD_READ_TIMEOUT_EN
          // pollCnt counts completed busy reads before this one
          if (pollCnt == POLL_LAST) begin
            limitHit  = 1'b1;
            stateNext = DONE;
          end else begin
            stateNext = SETUP;
          end
`else
          stateNext = SETUP;
`endif
        end else begin
          stateNext = DONE;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    RW        = (state != IDLE);
    busy      = (state != IDLE);
    RS        = regSelQ & (state != IDLE);
    enableOut = (state == EN_HIGH);
    valid     = (state == DONE);
`ifdef LCD_READ_TIMEOUT_EN
    timeout   = (state == DONE) & timedOut;
`else
    timeout   = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      regSelQ  <= 1'b0;
      pollQ    <= 1'b0;
      capture  <= '0;
      dataOut  <= '0;
      busyFlag <= 1'b0;
      addr     <= '0;
`ifdef LCD_READ_TIMEOUT_EN
      pollCnt  <= '0;
      timedOut <= 1'b0;
`endif
    end else begin
      state <= stateNext;
      if (stateNext == state && (state == SETUP || state == EN_HIGH))
        cnt <= cnt + 4'd1;
      else
        cnt <= '0;
      if (state == IDLE && start) begin
        regSelQ <= regSel;
        pollQ   <= pollBusy & ~regSel;
      end
      if (state == EN_HIGH && cnt == EN_LAST)
        capture <= lcdDataIn;
      // outputs load on entry to DONE so they are already valid during the valid pulse
      if (state == HOLD && stateNext == DONE) begin
        dataOut <= capture;
        if (!regSelQ) begin
          busyFlag <= capture[7];
          addr     <= capture[6:0];
        end
      end
`ifdef LCD_READ_TIMEOUT_EN
      if (state == IDLE && start) begin
        pollCnt  <= '0;
        timedOut <= 1'b0;
      end else if (state == HOLD && stateNext == SETUP) begin
        pollCnt <= pollCnt + 8'd1;
      end
      if (state == HOLD && stateNext == DONE)
        timedOut <= limitHit;
`endif
    end
  end

endmodule

// File: tb/tb_lcd_reader.sv
// tb_lcd_reader: randomized self-checking bench for lcd_reader against a cycle-timeline model
// derived from the read-cycle rules (pulse period, E window, completion cycle).
`timescale 1ns/1ps
module tb_lcd_reader;
  localparam int S  = 1;
  localparam int E  = 2;
  localparam int PL = 4;
  localparam int P  = S + E + 1;

  logic       clk = 1'b0;
  logic       rst, start, regSel, pollBusy;
  logic [7:0] lcdDataIn;
  logic       RS, RW, enableOut, busy, busyFlag, valid, timeout;
  logic [7:0] dataOut;
  logic [6:0] addr;

  lcd_reader #(.SETUP_CYCLES(S), .EN_HIGH_CYCLES(E), .POLL_LIMIT(PL)) dut (
    .clk(clk), .rst(rst), .start(start), .regSel(regSel), .pollBusy(pollBusy),
    .lcdDataIn(lcdDataIn), .RS(RS), .RW(RW), .enableOut(enableOut), .busy(busy),
    .dataOut(dataOut), .busyFlag(busyFlag), .addr(addr), .valid(valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: a transaction is mN identical read periods of P cycles, then one completion cycle.
  logic [7:0] pulseData [64];
  bit         mBusy = 0, mRS = 0, mPoll = 0, mTo = 0;
  int         mT = 0, mN = 1;
  logic [7:0] eData = '0;
  logic       eBF = 1'b0;
  logic [6:0] eAddr = '0;
  int         eTotal = 0;
  logic       prevEn = 1'b0;

  task automatic pin(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic planTxn();
    int n;
    mTo = 0;
    if (!mPoll) n = 1;
    else begin
      n = 1000;
      for (int k = 0; k < 64; k++)
        if (!pulseData[k][7]) begin n = k + 1; break; end
`ifdef LCD_READ_TIMEOUT_EN
      if (n > PL) begin n = PL; mTo = 1; end
`endif
    end
    mN = n;
  endtask

  task automatic tick();
    int ph, idx;
    logic en, vl;
    @(posedge clk);
    if (!rst) begin
      mBusy = 0; mT = 0; eData = '0; eBF = 1'b0; eAddr = '0;
    end else if (!mBusy) begin
      if (start) begin
        mBusy = 1; mT = 1; mRS = regSel; mPoll = pollBusy && !regSel;
        planTxn();
      end
    end else if (mT == mN * P + 1) begin
      mBusy = 0; mT = 0;
    end else begin
      mT++;
      if (mT == mN * P + 1 && mN <= 64) begin
        eData = pulseData[mN-1];
        if (!mRS) begin eBF = eData[7]; eAddr = eData[6:0]; end
      end
    end
    @(negedge clk);
    ph = mBusy ? (mT - 1) % P : 0;
    en = mBusy && mT <= mN * P && ph >= S && ph < S + E;
    vl = mBusy && mT == mN * P + 1;
    pin("ctrl", {RS, RW, enableOut, busy, valid, timeout},
        {mBusy && mRS, mBusy, en, mBusy, vl, vl && mTo});
    pin("data", {dataOut, busyFlag, addr}, {eData, eBF, eAddr});
    if (enableOut && !prevEn) eTotal++;
    prevEn = enableOut;
    #1;
    if (mBusy && mT <= mN * P && ph == S + E - 1) begin
      idx = (mT - 1) / P;
      lcdDataIn = (idx < 64) ? pulseData[idx] : 8'hFF;
    end else begin
      lcdDataIn = 8'($urandom);
    end
  endtask

  // noise: 1 = extra start pulse mid-transaction, 2 = start pulse in the valid cycle
  task automatic runTxn(input logic rs, input logic po, input int maxc, input int noise,
                        output int vc, output int pu, output logic to,
                        output logic [7:0] dO, output logic bf, output logic [6:0] ad);
    int e0;
    regSel = rs; pollBusy = po; start = 1'b1;
    tick();
    start = 1'b0;
    regSel = 1'($urandom); pollBusy = 1'($urandom);
    e0 = eTotal; vc = -1; to = 1'b0; dO = '0; bf = 1'b0; ad = '0;
    for (int c = 1; c <= maxc; c++) begin
      if (valid) begin
        vc = c; to = timeout; dO = dataOut; bf = busyFlag; ad = addr;
        break;
      end
      start = (noise == 1 && c == 2);
      tick();
    end
    start = 1'b0;
    pu = eTotal - e0;
    if (vc >= 0) begin
      start = (noise == 2);
      tick();
      start = 1'b0;
      tick();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int vc, pu, e0, c, expN;
    logic to, bf, seen, expTo, rs, po;
    logic [7:0] dO, v;
    logic [6:0] ad;

    rst = 1'b0; start = 1'b1; regSel = 1'b0; pollBusy = 1'b0; lcdDataIn = '0;
    for (int i = 0; i < 64; i++) pulseData[i] = 8'h00;

    // reset held with start asserted
    e0 = eTotal;
    repeat (3) tick();
    pin("rst_outs", {RS, RW, enableOut, busy, valid, timeout, dataOut, busyFlag, addr}, 0);
    pin("rst_noE", eTotal - e0, 0);
    rst = 1'b1; start = 1'b0;
    repeat (2) tick();
    pin("idle_after_rst", busy, 0);

    // data read
    pulseData[0] = 8'h41;
    runTxn(1'b1, 1'b0, 20, 0, vc, pu, to, dO, bf, ad);
    pin("rd_lat", vc, 5);
    pin("rd_pulses", pu, 1);
    pin("rd_data", dO, 8'h41);
    pin("rd_bf", bf, 0);
    pin("rd_addr", ad, 0);

    // busy-flag/address read, no poll
    pulseData[0] = 8'h8A;
    runTxn(1'b0, 1'b0, 20, 0, vc, pu, to, dO, bf, ad);
    pin("bf_lat", vc, 5);
    pin("bf_data", dO, 8'h8A);
    pin("bf_bf", bf, 1);
    pin("bf_addr", ad, 7'h0A);

    // data read with pollBusy set: poll ignored, BF/addr untouched
    pulseData[0] = 8'hC1;
    runTxn(1'b1, 1'b1, 20, 0, vc, pu, to, dO, bf, ad);
    pin("rd2_pulses", pu, 1);
    pin("rd2_data", dO, 8'hC1);
    pin("rd2_bf", bf, 1);
    pin("rd2_addr", ad, 7'h0A);

    // poll until BF clears
    pulseData[0] = 8'h80; pulseData[1] = 8'h80; pulseData[2] = 8'h80; pulseData[3] = 8'h05;
    runTxn(1'b0, 1'b1, 100, 0, vc, pu, to, dO, bf, ad);
    pin("poll_pulses", pu, 4);
    pin("poll_lat", vc, 17);
    pin("poll_bf", bf, 0);
    pin("poll_addr", ad, 7'h05);
    pin("poll_to", to, 0);

    // BF stuck high
    for (int i = 0; i < 64; i++) pulseData[i] = 8'hFF;
`ifdef LCD_READ_TIMEOUT_EN
    runTxn(1'b0, 1'b1, 100, 0, vc, pu, to, dO, bf, ad);
    pin("to_pulses", pu, 4);
    pin("to_lat", vc, 17);
    pin("to_flag", to, 1);
    pin("to_bf", bf, 1);
    pin("to_addr", ad, 7'h7F);
`else
    runTxn(1'b0, 1'b1, 85, 0, vc, pu, to, dO, bf, ad);
    pin("stuck_no_valid", vc, -1);
    pin("stuck_20_pulses", pu >= 20, 1);
    pin("stuck_to", timeout, 0);
    rst = 1'b0; tick(); rst = 1'b1; tick();
`endif

    // reset during the E pulse
    pulseData[0] = 8'h33;
    regSel = 1'b1; start = 1'b1; tick(); start = 1'b0;
    c = 0;
    while (!enableOut && c < 10) begin tick(); c++; end
    pin("en_reached", enableOut, 1);
    rst = 1'b0; tick();
    pin("rstE_en", enableOut, 0);
    pin("rstE_rw", RW, 0);
    rst = 1'b1;
    seen = 1'b0;
    repeat (10) begin tick(); if (valid) seen = 1'b1; end
    pin("rstE_no_valid", seen, 0);

    // start while busy and in the valid cycle are both dropped
    pulseData[0] = 8'h12;
    runTxn(1'b1, 1'b0, 20, 1, vc, pu, to, dO, bf, ad);
    pin("noise1_pulses", pu, 1);
    runTxn(1'b1, 1'b0, 20, 2, vc, pu, to, dO, bf, ad);
    seen = 1'b0;
    repeat (8) begin tick(); if (busy) seen = 1'b1; end
    pin("done_start_ignored", seen, 0);

    // randomized transactions
    for (int t = 0; t < 40; t++) begin
      rs = 1'($urandom); po = 1'($urandom);
      expN = $urandom_range(0, 5);
      for (int k = 0; k < 64; k++) begin
        v = 8'($urandom);
        if (po && !rs) v[7] = (k < expN);
        pulseData[k] = v;
      end
      expN = (po && !rs) ? expN + 1 : 1;
      expTo = 1'b0;
`ifdef LCD_READ_TIMEOUT_EN
      if (expN > PL) begin expN = PL; expTo = 1'b1; end
`endif
      runTxn(rs, po, 200, $urandom_range(0, 2), vc, pu, to, dO, bf, ad);
      pin("rnd_lat", vc, expN * P + 1);
      pin("rnd_pulses", pu, expN);
      pin("rnd_to", to, expTo);
      pin("rnd_data", dO, pulseData[expN-1]);
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
